// File: rtl/riscv_dift_trap_ctrl_if.sv
// riscv_dift_trap_ctrl_if: core-side signal bundle for the DIFT trap controller
interface riscv_dift_trap_ctrl_if;
  logic exception_i;
  logic ex_valid_i;
  logic [31:0] ex_pc_i;
  logic check_s1_i;
  logic check_s2_i;
  logic check_d_i;
  logic pipe_empty_i;
  logic trap_ack_i;
  logic csr_we_i;
  logic [1:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic halt_o;
  logic trap_req_o;
  logic [31:0] trap_pc_o;
  logic [4:0] trap_cause_o;
  modport master (
    output exception_i, ex_valid_i, ex_pc_i, check_s1_i, check_s2_i, check_d_i,
           pipe_empty_i, trap_ack_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, halt_o, trap_req_o, trap_pc_o, trap_cause_o
  );
  modport slave (
    input  exception_i, ex_valid_i, ex_pc_i, check_s1_i, check_s2_i, check_d_i,
           pipe_empty_i, trap_ack_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, halt_o, trap_req_o, trap_pc_o, trap_cause_o
  );
endinterface

// File: rtl/riscv_dift_trap_ctrl.sv
// riscv_dift_trap_ctrl: DIFT tag-violation counter and precise trap sequencer
module riscv_dift_trap_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  riscv_dift_trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [CNT_WIDTH-1:0] thr_q, thr_d, cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0] cause_q, cause_d;
  logic viol, trap, wr_ctrl, wr_cnt;
  logic [CNT_WIDTH:0] cnt_inc;
  logic [CNT_WIDTH+1:0] wdata_x, ctrl_rd;
  always_comb begin
    viol = bus.exception_i & bus.ex_valid_i;
    wr_ctrl = bus.csr_we_i & bus.csr_addr_i == 2'd0;
    wr_cnt = bus.csr_we_i & bus.csr_addr_i == 2'd1;
    cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
    trap = state_q == IDLE & viol & (mode_q[1] | (mode_q == 2'd1 & |thr_q & cnt_inc >= {1'b0, thr_q}));
    wdata_x = (CNT_WIDTH+2)'(bus.csr_wdata_i);
    ctrl_rd = {thr_q, mode_q};
    mode_d = wr_ctrl ? wdata_x[1:0] : mode_q;
    thr_d = wr_ctrl ? wdata_x[CNT_WIDTH+1:2] : thr_q;
    cnt_d = wr_cnt ? bus.csr_wdata_i[CNT_WIDTH-1:0] : viol & |mode_q & ~&cnt_q ? cnt_inc[CNT_WIDTH-1:0] : cnt_q;
    epc_d = trap ? bus.ex_pc_i : epc_q;
    cause_d = trap ? {1'b0, ~mode_q[1], bus.check_d_i, bus.check_s2_i, bus.check_s1_i}
                   : {cause_q[4] | (viol & state_q != IDLE), cause_q[3:0]};
    state_d = trap ? DRAIN
            : state_q == DRAIN & bus.pipe_empty_i ? REQ
            : state_q == REQ & bus.trap_ack_i ? IDLE
            : state_q;
    bus.halt_o = state_q != IDLE | trap;
    bus.trap_req_o = state_q == REQ;
    bus.trap_pc_o = epc_q;
    bus.trap_cause_o = cause_q;
    bus.csr_rdata_o = bus.csr_addr_i == 2'd0 ? 32'(ctrl_rd)
                    : bus.csr_addr_i == 2'd1 ? 32'(cnt_q)
                    : bus.csr_addr_i == 2'd2 ? epc_q
                    : {27'b0, cause_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      thr_q <= '0;
      cnt_q <= '0;
      epc_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      thr_q <= thr_d;
      cnt_q <= cnt_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_riscv_dift_trap_ctrl.sv
// tb_riscv_dift_trap_ctrl: directed and random checks against a behavioural model
module tb_riscv_dift_trap_ctrl;
  localparam longint MAXC = 64'hFFFF_FFFF;
  localparam int P_IDLE = 0;
  localparam int P_DRAIN = 1;
  localparam int P_REQ = 2;
  logic clk = 1'b0;
  logic rst;
  int ncmp = 0;
  int nfail = 0;
  longint m_cnt, m_thr;
  int m_mode, m_phase;
  logic [31:0] m_epc;
  logic [4:0] m_cause;
  riscv_dift_trap_ctrl_if bus ();
  riscv_dift_trap_ctrl #(.CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return 32'((m_thr << 2) | longint'(m_mode));
      2'd1: return 32'(m_cnt);
      2'd2: return m_epc;
      default: return {27'b0, m_cause};
    endcase
  endfunction
  task automatic drive(input logic exc, vld, input logic [31:0] pc, input logic [2:0] cb,
                       input logic pe, ack, we, input logic [1:0] addr, input logic [31:0] wd);
    bus.exception_i = exc;
    bus.ex_valid_i = vld;
    bus.ex_pc_i = pc;
    bus.check_s1_i = cb[0];
    bus.check_s2_i = cb[1];
    bus.check_d_i = cb[2];
    bus.pipe_empty_i = pe;
    bus.trap_ack_i = ack;
    bus.csr_we_i = we;
    bus.csr_addr_i = addr;
    bus.csr_wdata_i = wd;
  endtask
  task automatic cyc(input logic exc, vld, input logic [31:0] pc, input logic [2:0] cb,
                     input logic pe, ack, we, input logic [1:0] addr, input logic [31:0] wd);
    logic viol, tc;
    @(negedge clk);
    drive(exc, vld, pc, cb, pe, ack, we, addr, wd);
    #1;
    viol = exc & vld;
    tc = m_phase == P_IDLE && viol && (m_mode >= 2 || (m_mode == 1 && m_thr != 0 && m_cnt + 1 >= m_thr));
    chk("halt", 32'(bus.halt_o), 32'(m_phase != P_IDLE || tc));
    chk("trap_req", 32'(bus.trap_req_o), 32'(m_phase == P_REQ));
    chk("trap_pc", bus.trap_pc_o, m_epc);
    chk("trap_cause", 32'(bus.trap_cause_o), 32'(m_cause));
    chk("csr_rdata", bus.csr_rdata_o, m_read(addr));
    if (we && addr == 2'd1) m_cnt = longint'(wd);
    else if (viol && m_mode != 0 && m_cnt < MAXC) m_cnt++;
    if (tc) begin
      m_epc = pc;
      m_cause = {1'b0, m_mode == 1, cb};
    end else if (viol && m_phase != P_IDLE) m_cause[4] = 1'b1;
    if (tc) m_phase = P_DRAIN;
    else if (m_phase == P_DRAIN && pe) m_phase = P_REQ;
    else if (m_phase == P_REQ && ack) m_phase = P_IDLE;
    if (we && addr == 2'd0) begin
      m_mode = int'(wd[1:0]);
      m_thr = longint'(wd >> 2);
    end
    @(posedge clk);
  endtask
  task automatic nop(input int n, input logic pe, input logic ack);
    repeat (n) cyc(0, 0, 0, 0, pe, ack, 0, 0, 0);
  endtask
  task automatic rd(input logic [1:0] a);
    cyc(0, 0, 0, 0, 0, 0, 0, a, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(0, 0, 0, 0, 0, 0, 1, a, d);
  endtask
  task automatic viol_at(input logic [31:0] pc, input logic [2:0] cb, input logic pe);
    cyc(1, 1, pc, cb, pe, 0, 0, 2'd1, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    m_thr = 0;
    m_mode = 0;
    m_phase = P_IDLE;
    m_epc = '0;
    m_cause = '0;
    chk("rst_halt", 32'(bus.halt_o), 32'd0);
    chk("rst_req", 32'(bus.trap_req_o), 32'd0);
    chk("rst_ctrl", bus.csr_rdata_o, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    do_reset();
    for (int a = 0; a < 4; a++) rd(2'(a));
    wr(0, 32'd2);
    viol_at(32'h0000_1A40, 3'b001, 0);
    nop(2, 0, 0);
    nop(1, 1, 0);
    nop(2, 1, 0);
    nop(1, 1, 1);
    #1;
    chk("trap_epc", bus.trap_pc_o, 32'h0000_1A40);
    chk("trap_cause1", 32'(bus.trap_cause_o), 32'd1);
    chk("halt_after_ack", 32'(bus.halt_o), 32'd0);
    rd(1);
    wr(1, 32'd0);
    wr(0, (32'd3 << 2) | 32'd1);
    viol_at(32'h100, 3'b010, 0);
    viol_at(32'h104, 3'b010, 0);
    viol_at(32'h108, 3'b100, 0);
    #1;
    chk("log_epc", bus.trap_pc_o, 32'h108);
    chk("log_esc", 32'(bus.trap_cause_o[3]), 32'd1);
    nop(1, 1, 0);
    nop(1, 1, 1);
    wr(0, 32'd0);
    wr(1, 32'd0);
    repeat (10) viol_at(32'h400, 3'b111, 1);
    rd(1);
    #1;
    chk("off_count", bus.csr_rdata_o, 32'd0);
    wr(0, 32'd2);
    viol_at(32'h200, 3'b001, 0);
    viol_at(32'h204, 3'b010, 0);
    #1;
    chk("nest_missed", 32'(bus.trap_cause_o[4]), 32'd1);
    chk("nest_epc", bus.trap_pc_o, 32'h200);
    nop(1, 1, 0);
    nop(1, 1, 1);
    viol_at(32'h300, 3'b100, 1);
    #1;
    chk("nest_clear", 32'(bus.trap_cause_o), 32'h4);
    nop(1, 1, 0);
    nop(1, 1, 1);
    wr(0, 32'd1);
    wr(1, 32'h10);
    cyc(1, 1, 32'h500, 3'b001, 0, 0, 1, 2'd1, 32'd0);
    rd(1);
    wr(1, 32'hFFFF_FFFF);
    viol_at(32'h600, 3'b001, 0);
    rd(1);
    #1;
    chk("sat_count", bus.csr_rdata_o, 32'hFFFF_FFFF);
    wr(0, (32'd5 << 2) | 32'd1);
    viol_at(32'h700, 3'b011, 0);
    #1;
    chk("sat_esc", 32'(bus.trap_cause_o), 32'hB);
    nop(1, 1, 0);
    nop(1, 1, 1);
    wr(0, 32'd2);
    viol_at(32'h800, 3'b001, 1);
    nop(1, 1, 0);
    #1;
    chk("req_before_rst", 32'(bus.trap_req_o), 32'd1);
    do_reset();
    nop(2, 1, 1);
    for (int a = 0; a < 4; a++) rd(2'(a));
    for (int i = 0; i < 1500; i++) begin
      automatic int r = int'($urandom_range(0, 19));
      automatic logic [31:0] wd;
      automatic logic [1:0] wa = 2'($urandom_range(0, 3));
      automatic logic we = 1'b0;
      if (r == 0) begin
        we = 1'b1;
        wa = 2'd0;
        wd = (32'($urandom_range(0, 4)) << 2) | 32'($urandom_range(0, 3));
      end else if (r == 1) begin
        automatic int k = int'($urandom_range(0, 3));
        we = 1'b1;
        wa = 2'd1;
        wd = k == 0 ? 32'd0 : k == 1 ? 32'($urandom_range(0, 6)) : k == 2 ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      end else if (r == 2) begin
        we = 1'b1;
        wa = 2'($urandom_range(2, 3));
        wd = $urandom;
      end else wd = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), we, wa, wd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
